// File: rtl/seg_decoder.sv
// Debounces a pair of 7-segment glyph buses and decodes them back to a hex
// byte, delivered over a valid/ready handshake with error/overrun flags.
module seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segdeci_1,
  input  logic [6:0] segdeci_2,
  input  logic       segdeci_ready,
  output logic [7:0] segdeco_data,
  output logic       segdeco_valid,
  output logic       segdeco_error,
  output logic       segdeco_overrun
);

  localparam logic [7:0] STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [13:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        overrun_q, overrun_d;

  logic [13:0] cur;
  logic        match;
  logic        capture;
  logic        blank;
  logic        legal;
  logic        load;
  logic [4:0]  dec_lo;
  logic [4:0]  dec_hi;

  // {legal, nibble}
  function automatic logic [4:0] glyph_dec(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    cur     = {segdeci_2, segdeci_1};
    match   = (cur == prev_q);
    capture = match && (cnt_q == STABLE_M1);
    blank   = (cur == 14'd0);
    dec_lo  = glyph_dec(segdeci_1);
    dec_hi  = glyph_dec(segdeci_2);
    legal   = dec_lo[4] && dec_hi[4];
    load    = capture && !blank && legal;
  end

  always_comb begin
    prev_d    = cur;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    error_d   = capture && !blank && !legal;

    if (!match) begin
      cnt_d = 8'd0;
    end else if (cnt_q != STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A pending byte may only be replaced when it is accepted this edge.
    if (load) begin
      if (!valid_q || segdeci_ready) begin
        data_d  = {dec_hi[3:0], dec_lo[3:0]};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && segdeci_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign segdeco_data    = data_q;
  assign segdeco_valid   = valid_q;
  assign segdeco_error   = error_q;
  assign segdeco_overrun = overrun_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_seg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] segdeci_1 = '0;
  logic [6:0] segdeci_2 = '0;
  logic       segdeci_ready = 1'b0;
  logic [7:0] segdeco_data;
  logic       segdeco_valid;
  logic       segdeco_error;
  logic       segdeco_overrun;

  seg_decoder #(.STABLE_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .segdeci_1       (segdeci_1),
    .segdeci_2       (segdeci_2),
    .segdeci_ready   (segdeci_ready),
    .segdeco_data    (segdeco_data),
    .segdeco_valid   (segdeco_valid),
    .segdeco_error   (segdeco_error),
    .segdeco_overrun (segdeco_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic       pv = 1'b0;
  logic [7:0] pd = '0;

  task automatic mon_pop(input bit err, input logic [7:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL evt_unexpected: got err=%0b data=%h cyc=%0d, queue empty",
               err, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.err != err || e.at != cyc || (!err && e.data != d)) begin
        failures++;
        $display("FAIL evt: got err=%0b data=%h cyc=%0d want err=%0b data=%h cyc=%0d",
                 err, d, cyc, e.err, e.data, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pd = '0;
    end else begin
      if (segdeco_error)
        mon_pop(1'b1, segdeco_data);
      if (segdeco_valid && (!pv || segdeco_data != pd))
        mon_pop(1'b0, segdeco_data);
      pv = segdeco_valid;
      pd = segdeco_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [6:0] hi, input logic [6:0] lo);
    segdeci_2 = hi;
    segdeci_1 = lo;
  endtask

  task automatic expect_evt(input bit err, input logic [7:0] d,
                            input int dly);
    exp_t e;
    e.err = err;
    e.data = d;
    e.at = cyc + dly;
    q.push_back(e);
  endtask

  task automatic accept();
    segdeci_ready = 1'b1;
    step(1);
    segdeci_ready = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b0;
    step(2);
    chk("rst_data", segdeco_data, 8'h00);
    chk("rst_valid", {7'd0, segdeco_valid}, 8'h00);
    chk("rst_error", {7'd0, segdeco_error}, 8'h00);
    chk("rst_overrun", {7'd0, segdeco_overrun}, 8'h00);
    rst = 1'b1;
    step(1);

    // basic decode 0x12
    drive(7'h06, 7'h5B);
    expect_evt(1'b0, 8'h12, 5);
    step(4);
    chk("basic_early", {7'd0, segdeco_valid}, 8'h00);
    step(1);
    chk("basic_valid", {7'd0, segdeco_valid}, 8'h01);
    accept();
    chk("basic_drop", {7'd0, segdeco_valid}, 8'h00);
    chk("basic_hold", segdeco_data, 8'h12);
    step(3);
    chk("basic_norecap", {7'd0, segdeco_valid}, 8'h00);

    // glitch rejection
    drive(7'h7F, 7'h3F);
    step(2);
    drive(7'h77, 7'h7C);
    expect_evt(1'b0, 8'hAB, 5);
    step(5);
    chk("glitch_valid", {7'd0, segdeco_valid}, 8'h01);
    chk("glitch_data", segdeco_data, 8'hAB);
    accept();

    // illegal glyphs
    drive(7'h06, 7'h7E);
    expect_evt(1'b1, 8'h00, 5);
    step(6);
    chk("ill_valid", {7'd0, segdeco_valid}, 8'h00);
    chk("ill_data", segdeco_data, 8'hAB);
    drive(7'h00, 7'h3F);
    expect_evt(1'b1, 8'h00, 5);
    step(6);
    chk("ill0_valid", {7'd0, segdeco_valid}, 8'h00);

    // capture and accept on the same edge
    drive(7'h06, 7'h5B);
    expect_evt(1'b0, 8'h12, 5);
    step(5);
    drive(7'h4F, 7'h66);
    expect_evt(1'b0, 8'h34, 5);
    step(4);
    accept();
    chk("sim_valid", {7'd0, segdeco_valid}, 8'h01);
    chk("sim_data", segdeco_data, 8'h34);
    chk("sim_ovr", {7'd0, segdeco_overrun}, 8'h00);
    accept();

    // overrun
    drive(7'h06, 7'h5B);
    expect_evt(1'b0, 8'h12, 5);
    step(5);
    drive(7'h4F, 7'h66);
    step(6);
    chk("ovr_data", segdeco_data, 8'h12);
    chk("ovr_valid", {7'd0, segdeco_valid}, 8'h01);
    chk("ovr_flag", {7'd0, segdeco_overrun}, 8'h01);
    accept();
    chk("ovr_valid2", {7'd0, segdeco_valid}, 8'h00);
    chk("ovr_sticky", {7'd0, segdeco_overrun}, 8'h01);

    // reset clears overrun, then blank
    rst = 1'b0;
    step(1);
    chk("rst2_ovr", {7'd0, segdeco_overrun}, 8'h00);
    drive(7'h00, 7'h00);
    rst = 1'b1;
    step(20);
    chk("blank_valid", {7'd0, segdeco_valid}, 8'h00);

    // reset mid-count
    drive(7'h6D, 7'h7D);
    c = cyc;
    step(3);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    expect_evt(1'b0, 8'h56, 5);
    step(4);
    chk("rstmid_early", {7'd0, segdeco_valid}, 8'h00);
    step(1);
    chk("rstmid_valid", {7'd0, segdeco_valid}, 8'h01);
    chk("rstmid_data", segdeco_data, 8'h56);
    chk("rstmid_cyc", 8'(cyc - c), 8'd8);

    step(4);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL evt_missing: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
